uart_rx_fifo_param: RTL and testbench
=====================================

UART_RX_FIFO_PARAM -- requirements
Module: uart_rx_fifo_param

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning received character width in bits (5..8).
REQ-002 SHALL have parameter DEPTH, default 16, meaning FIFO entry count (power of two, 4..256); AW = log2(DEPTH).
REQ-003 SHALL have parameter TOUT_CYC, default 4096, meaning the character-timeout idle threshold in DSP_CLK cycles.
REQ-004 SHALL have ports, one per line (name  direction  width  meaning):
- DSP_CLK  in  1  sole clock.
- RESETn  in  1  asynchronous active-low reset.
- DSP_CEn  in  1  DSP chip enable, active low.
- DSP_WEn  in  1  high = read, low = write.
- DSP_ADDR  in  [4:1]  register select.
- DSP_WDATA  in  16  write data.
- DSP_RDATA  out  16  read data.
- FIFOEn  in  1  FIFO mode enable.
- RxDone  in  1  async character-complete level from the Rx controller.
- RxData  in  DATA_W  received character.
- RxParityErr  in  1  parity error for the current character.
- RxFrameErr  in  1  framing error for the current character.
- RxFIFO_Empty  out  1  FIFO empty.
- RxFIFO_Full  out  1  FIFO full.
- RxFIFO_Level  out  AW+1  occupancy, 0..DEPTH.
- RxTrig  out  1  level >= programmed trigger.
- RxTimeout  out  1  character timeout.
- OverrunError  out  1  sticky overrun.
- RxIRQ  out  1  RxTrig | RxTimeout | OverrunError | entry error at head.

Function
REQ-005 SHALL synchronise RxDone, RxData, RxParityErr and RxFrameErr through two DSP_CLK flops and push exactly one entry {FE, PE, data} on each rising edge of the synchronised RxDone.
REQ-006 SHALL form a read strobe only on the first cycle of a read access: !DSP_CEn & DSP_WEn, where DSP_CEn was high in the previous cycle; a write strobe likewise uses !DSP_WEn.
REQ-007 SHALL, on a read strobe at ADDR 0, register DSP_RDATA = {6'd0, FE, PE, zero-extended data} of the head entry and pop it one cycle later; when empty, it SHALL return 16'h0000 and not move pointers.
REQ-008 SHALL, on a read strobe at ADDR 1, return {OverrunError, RxTimeout, RxTrig, RxFIFO_Full, RxFIFO_Empty, zero pad, RxFIFO_Level}, with Level in bits [AW:0] and status in [15:11]; reading SHALL clear OverrunError.
REQ-009 SHALL, on a write strobe at ADDR 1, treat bit0 as flush (pointers, level and timeout cleared next cycle, storage untouched) and latch bits[2:1] as TRIG_SEL.
REQ-010 SHALL set trigger threshold per TRIG_SEL: 0 -> 1; 1 -> DEPTH/4; 2 -> DEPTH/2; 3 -> DEPTH-2.
REQ-011 SHALL use AW+1-bit read/write pointers, with level = wp - rp modulo 2^(AW+1), Empty = (level == 0) and Full = (level == DEPTH).
REQ-012 SHALL, on a push when full, discard the new character, keep the stored contents and pointers, and set OverrunError.
REQ-013 SHALL, on a simultaneous push and pop in the same cycle, perform both; the level is unchanged, and when full the push succeeds without overrun.
REQ-014 SHALL, when FIFOEn = 0, behave as depth 1: Full = (level == 1), with the same overrun rule.
REQ-015 SHALL drive an idle counter that resets on every push or pop, counts while non-empty, saturates at TOUT_CYC, and asserts RxTimeout while count == TOUT_CYC; RxTimeout SHALL clear on the next pop or flush.
REQ-016 SHALL make pointer wrap seamless at DEPTH-1 -> 0 with no lost or duplicated entries.
REQ-017 SHALL compute all status outputs combinationally from registered state, except DSP_RDATA, which SHALL be registered and zero outside a read strobe cycle.

Reset
REQ-018 SHALL, on RESETn low, asynchronously clear pointers, sync flops, idle counter, OverrunError, TRIG_SEL (to 0) and DSP_RDATA; RxFIFO_Empty = 1 and all other outputs = 0.
REQ-019 SHALL, when reset asserts mid-access or mid-push, abort the operation with no partial pointer update; storage contents SHALL be don't-care after reset.

Structure
REQ-020 SHALL place register addresses, TRIG_SEL encodings and status bit positions in shared package uart_pkg.
REQ-021 SHALL use one sub-module, uart_sync_fifo_mem, holding the DEPTH x (DATA_W+2) storage, with one write port and a combinational read port.

Verification
REQ-022 SHALL verify fill to full: with DEPTH=16, push 0x00..0x0F -> Full=1, Level=16, RxTrig=1 at TRIG_SEL=3 from level 14, and no overrun.
REQ-023 SHALL verify overrun: a 17th push of 0xAA when full -> OverrunError=1, head still 0x00; a status read clears it and returns bit15=1.
REQ-024 SHALL verify wrap: 40 interleaved push/pop pairs -> read data sequence matches write sequence, Level never exceeds 1.
REQ-025 SHALL verify errors: push 0x55 with PE=1, FE=0 -> ADDR 0 read returns 16'h0155 and RxIRQ=1 before the pop.
REQ-026 SHALL verify timeout: with TOUT_CYC=64, push one byte and stay idle -> RxTimeout rises exactly 64 cycles after the push; a pop clears it.
REQ-027 SHALL verify flush and held CEn: write 0x0001 to ADDR 1 with 5 entries -> Empty=1 next cycle; holding a read access for 4 cycles pops exactly one entry.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared register map, trigger-select encodings and status bit positions
// for the UART receive FIFO.
package uart_pkg;

  localparam logic [3:0] ADDR_RX  = 4'd0;
  localparam logic [3:0] ADDR_CSR = 4'd1;

  localparam int unsigned CSR_FLUSH_BIT = 0;
  localparam int unsigned RD_FE_BIT     = 9;
  localparam int unsigned RD_PE_BIT     = 8;

  localparam int unsigned ST_OVR   = 15;
  localparam int unsigned ST_TOUT  = 14;
  localparam int unsigned ST_TRIG  = 13;
  localparam int unsigned ST_FULL  = 12;
  localparam int unsigned ST_EMPTY = 11;

  typedef enum logic [1:0] {
    TRIG_ONE  = 2'd0,
    TRIG_QTR  = 2'd1,
    TRIG_HALF = 2'd2,
    TRIG_NEAR = 2'd3
  } trig_sel_e;

  function automatic int unsigned trig_threshold(input trig_sel_e sel, input int unsigned depth);
    case (sel)
      TRIG_QTR:  return depth / 4;
      TRIG_HALF: return depth / 2;
      TRIG_NEAR: return depth - 2;
      default:   return 1;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_fifo_param_if.sv
// Bundled buses: the FIFO storage port used inside the block, and the DSP
// register bus used by hosts driving the block.
interface uart_fifo_mem_if #(
  parameter int unsigned AW = 4,
  parameter int unsigned W  = 10
);
  logic          we;
  logic [AW-1:0] waddr;
  logic [W-1:0]  wdata;
  logic [AW-1:0] raddr;
  logic [W-1:0]  rdata;

  modport master (output we, waddr, wdata, raddr, input rdata);
  modport slave  (input we, waddr, wdata, raddr, output rdata);
endinterface

interface uart_dsp_if;
  logic        cen;
  logic        wen;
  logic [4:1]  addr;
  logic [15:0] wdata;
  logic [15:0] rdata;

  modport master (output cen, wen, addr, wdata, input rdata);
  modport slave  (input cen, wen, addr, wdata, output rdata);
endinterface

// File: rtl/uart_sync_fifo_mem.sv
// DEPTH x W FIFO storage: one synchronous write port, one combinational read port.
module uart_sync_fifo_mem #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned W     = 10
) (
  input logic            clk,
  uart_fifo_mem_if.slave mp
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (mp.we) mem_q[mp.waddr] <= mp.wdata;
  end

  assign mp.rdata = mem_q[mp.raddr];

endmodule

// File: rtl/uart_rx_fifo_param.sv
// UART receive FIFO: synchronises the Rx character strobe, queues {FE,PE,data}
// and exposes data/status/control registers on the DSP bus.
module uart_rx_fifo_param
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned TOUT_CYC = 4096
) (
  input  logic                   DSP_CLK,
  input  logic                   RESETn,
  input  logic                   DSP_CEn,
  input  logic                   DSP_WEn,
  input  logic [4:1]             DSP_ADDR,
  input  logic [15:0]            DSP_WDATA,
  output logic [15:0]            DSP_RDATA,
  input  logic                   FIFOEn,
  input  logic                   RxDone,
  input  logic [DATA_W-1:0]      RxData,
  input  logic                   RxParityErr,
  input  logic                   RxFrameErr,
  output logic                   RxFIFO_Empty,
  output logic                   RxFIFO_Full,
  output logic [$clog2(DEPTH):0] RxFIFO_Level,
  output logic                   RxTrig,
  output logic                   RxTimeout,
  output logic                   OverrunError,
  output logic                   RxIRQ
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned EW = DATA_W + 2;
  localparam int unsigned CW = $clog2(TOUT_CYC + 1);

  logic          done_s1_q, done_s2_q, done_s3_q;
  logic [EW-1:0] ent_s1_q, ent_s2_q;
  logic          cen_prev_q;
  logic [AW:0]   wp_q, wp_d, rp_q, rp_d;
  logic          pop_pend_q, pop_pend_d;
  logic          ovr_q, ovr_d;
  trig_sel_e     trig_sel_q, trig_sel_d;
  logic [CW-1:0] idle_q, idle_d;
  logic [15:0]   rdata_q, rdata_d;

  logic [AW:0]   level, thr;
  logic [EW-1:0] head;
  logic [15:0]   stat_word;
  logic          empty, full, tout, push, pop, push_ok;
  logic          rd_stb, wr_stb, data_rd, stat_rd, csr_wr, flush;
  logic          unused_wdata;

  uart_fifo_mem_if #(.AW(AW), .W(EW)) mem_bus ();
  uart_sync_fifo_mem #(.DEPTH(DEPTH), .W(EW)) u_mem (.clk(DSP_CLK), .mp(mem_bus));

  assign level   = wp_q - rp_q;
  assign empty   = (level == '0);
  assign full    = FIFOEn ? (level == (AW+1)'(DEPTH)) : (level == (AW+1)'(1));
  assign thr     = (AW+1)'(trig_threshold(trig_sel_q, DEPTH));
  assign tout    = (idle_q == CW'(TOUT_CYC));
  assign head    = mem_bus.rdata;

  assign rd_stb  = ~DSP_CEn & DSP_WEn & cen_prev_q;
  assign wr_stb  = ~DSP_CEn & ~DSP_WEn & cen_prev_q;
  assign data_rd = rd_stb & (DSP_ADDR == ADDR_RX);
  assign stat_rd = rd_stb & (DSP_ADDR == ADDR_CSR);
  assign csr_wr  = wr_stb & (DSP_ADDR == ADDR_CSR);
  assign flush   = csr_wr & DSP_WDATA[CSR_FLUSH_BIT];

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push    = done_s2_q & ~done_s3_q;
  assign pop     = pop_pend_q & ~empty;
  assign push_ok = push & (~full | pop);

  assign mem_bus.we    = push_ok & ~flush;
  assign mem_bus.waddr = wp_q[AW-1:0];
  assign mem_bus.wdata = ent_s2_q;
  assign mem_bus.raddr = rp_q[AW-1:0];

  assign unused_wdata = ^DSP_WDATA[15:3];

  always_comb begin
    stat_word           = '0;
    stat_word[AW:0]     = level;
    stat_word[ST_EMPTY] = empty;
    stat_word[ST_FULL]  = full;
    stat_word[ST_TRIG]  = RxTrig;
    stat_word[ST_TOUT]  = tout;
    stat_word[ST_OVR]   = ovr_q;
  end

  always_comb begin
    wp_d       = wp_q;
    rp_d       = rp_q;
    if (push_ok) wp_d = wp_q + 1'b1;
    if (pop)     rp_d = rp_q + 1'b1;
    if (flush) begin
      wp_d = '0;
      rp_d = '0;
    end

    pop_pend_d = data_rd & ~empty;
    ovr_d      = (ovr_q & ~stat_rd) | (push & full & ~pop);
    trig_sel_d = csr_wr ? trig_sel_e'(DSP_WDATA[2:1]) : trig_sel_q;

    idle_d = idle_q;
    if (flush || push || pop || empty) idle_d = '0;
    else if (!tout)                    idle_d = idle_q + 1'b1;

    rdata_d = '0;
    if (data_rd && !empty) begin
      rdata_d[DATA_W-1:0] = head[DATA_W-1:0];
      rdata_d[RD_PE_BIT]  = head[EW-2];
      rdata_d[RD_FE_BIT]  = head[EW-1];
    end else if (stat_rd) begin
      rdata_d = stat_word;
    end
  end

  always_ff @(posedge DSP_CLK or negedge RESETn) begin
    if (!RESETn) begin
      done_s1_q  <= 1'b0;
      done_s2_q  <= 1'b0;
      done_s3_q  <= 1'b0;
      ent_s1_q   <= '0;
      ent_s2_q   <= '0;
      cen_prev_q <= 1'b1;
      wp_q       <= '0;
      rp_q       <= '0;
      pop_pend_q <= 1'b0;
      ovr_q      <= 1'b0;
      trig_sel_q <= TRIG_ONE;
      idle_q     <= '0;
      rdata_q    <= '0;
    end else begin
      done_s1_q  <= RxDone;
      done_s2_q  <= done_s1_q;
      done_s3_q  <= done_s2_q;
      ent_s1_q   <= {RxFrameErr, RxParityErr, RxData};
      ent_s2_q   <= ent_s1_q;
      cen_prev_q <= DSP_CEn;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      pop_pend_q <= pop_pend_d;
      ovr_q      <= ovr_d;
      trig_sel_q <= trig_sel_d;
      idle_q     <= idle_d;
      rdata_q    <= rdata_d;
    end
  end

  assign DSP_RDATA    = rdata_q;
  assign RxFIFO_Empty = empty;
  assign RxFIFO_Full  = full;
  assign RxFIFO_Level = level;
  assign RxTrig       = (level >= thr);
  assign RxTimeout    = tout;
  assign OverrunError = ovr_q;
  assign RxIRQ        = RxTrig | tout | ovr_q | (~empty & (head[EW-1] | head[EW-2]));

endmodule

// File: tb/tb_uart_rx_fifo_param.sv
// Directed bench for uart_rx_fifo_param; read responses are checked by a
// monitor against a scoreboard queue filled when each read is issued.
`timescale 1ns/1ps
module tb_uart_rx_fifo_param;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       fifo_en, rx_done, rx_pe, rx_fe;
  logic [7:0] rx_data;
  logic       empty, full, trig, tout, ovr, irq;
  logic [4:0] level;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mon_exp;
  logic        mon_stb;
  logic        mon_prev_cen = 1'b1;

  uart_dsp_if bus ();

  always #5 clk = ~clk;

  uart_rx_fifo_param #(.DATA_W(8), .DEPTH(16), .TOUT_CYC(64)) dut (
    .DSP_CLK(clk), .RESETn(rst_n),
    .DSP_CEn(bus.cen), .DSP_WEn(bus.wen), .DSP_ADDR(bus.addr),
    .DSP_WDATA(bus.wdata), .DSP_RDATA(bus.rdata),
    .FIFOEn(fifo_en), .RxDone(rx_done), .RxData(rx_data),
    .RxParityErr(rx_pe), .RxFrameErr(rx_fe),
    .RxFIFO_Empty(empty), .RxFIFO_Full(full), .RxFIFO_Level(level),
    .RxTrig(trig), .RxTimeout(tout), .OverrunError(ovr), .RxIRQ(irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: DSP_RDATA is valid the cycle after a read strobe, zero otherwise.
  always @(posedge clk) begin
    mon_stb = rst_n && !bus.cen && bus.wen && mon_prev_cen;
    mon_prev_cen = rst_n ? bus.cen : 1'b1;
    #1;
    if (rst_n) begin
      if (mon_stb) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rdata_unexpected: actual 0x%0h required no read", bus.rdata);
        end else begin
          mon_exp = exp_q.pop_front();
          check("rdata", bus.rdata, mon_exp);
        end
      end else begin
        check("rdata_idle", bus.rdata, 16'h0000);
      end
    end
  end

  task automatic push_char(input logic [7:0] d, input logic pe, input logic fe);
    @(negedge clk); rx_data = d; rx_pe = pe; rx_fe = fe;
    @(negedge clk); rx_done = 1'b1;
    repeat (3) @(negedge clk);
    rx_done = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic dsp_read(input logic [3:0] a, input logic [15:0] exp, input int hold);
    @(negedge clk); bus.cen = 1'b0; bus.wen = 1'b1; bus.addr = a; exp_q.push_back(exp);
    repeat (hold) @(negedge clk);
    bus.cen = 1'b1;
    @(negedge clk);
  endtask

  task automatic dsp_write(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk); bus.cen = 1'b0; bus.wen = 1'b0; bus.addr = a; bus.wdata = d;
    @(negedge clk); bus.cen = 1'b1; bus.wen = 1'b1;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  logic [7:0] d;
  logic       pe, fe;
  int         n;

  initial begin
    bus.cen = 1'b1; bus.wen = 1'b1; bus.addr = '0; bus.wdata = '0;
    fifo_en = 1'b1; rx_done = 1'b0; rx_pe = 1'b0; rx_fe = 1'b0; rx_data = '0;
    repeat (3) @(negedge clk);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_level", level, 0);
    check("rst_trig", trig, 0);
    check("rst_tout", tout, 0);
    check("rst_ovr", ovr, 0);
    check("rst_irq", irq, 0);
    check("rst_rdata", bus.rdata, 0);
    rst_n = 1'b1;

    // Fill to full with trigger at DEPTH-2.
    dsp_write(ADDR_CSR, 16'h0006);
    for (int i = 0; i < 16; i++) begin
      push_char(8'(i), 1'b0, 1'b0);
      check("fill_level", level, i + 1);
      check("fill_trig", trig, (i + 1 >= 14));
      check("fill_full", full, (i == 15));
      check("fill_irq", irq, (i + 1 >= 14));
    end
    check("fill_ovr", ovr, 0);
    dsp_read(ADDR_CSR, 16'h3010, 1);

    // Overrun: discarded character, sticky flag cleared by status read.
    push_char(8'hAA, 1'b0, 1'b0);
    check("ovr_set", ovr, 1);
    check("ovr_level", level, 16);
    dsp_read(ADDR_CSR, 16'hB010, 1);
    check("ovr_cleared", ovr, 0);
    for (int i = 0; i < 16; i++) dsp_read(ADDR_RX, 16'(i), 1);
    check("drain_empty", empty, 1);
    dsp_read(ADDR_RX, 16'h0000, 1);
    check("empty_read_level", level, 0);

    // Wrap: interleaved push/pop pairs across the pointer boundary.
    dsp_write(ADDR_CSR, 16'h0000);
    for (int i = 0; i < 40; i++) begin
      d = 8'(i * 37 + 5); pe = (i % 3 == 0); fe = (i % 5 == 0);
      push_char(d, pe, fe);
      check("wrap_level_push", level, 1);
      dsp_read(ADDR_RX, {6'b0, fe, pe, d}, 1);
      check("wrap_level_pop", level, 0);
    end

    // Entry errors raise the interrupt while at the head.
    dsp_write(ADDR_CSR, 16'h0006);
    push_char(8'h55, 1'b1, 1'b0);
    check("pe_trig", trig, 0);
    check("pe_irq", irq, 1);
    dsp_read(ADDR_RX, 16'h0155, 1);
    check("pe_irq_after_pop", irq, 0);
    push_char(8'h3C, 1'b0, 1'b1);
    check("fe_irq", irq, 1);
    dsp_read(ADDR_RX, 16'h023C, 1);

    // Character timeout.
    @(negedge clk); rx_data = 8'h11; rx_pe = 1'b0; rx_fe = 1'b0;
    @(negedge clk); rx_done = 1'b1;
    n = 0;
    while (empty && n < 20) begin @(negedge clk); n++; end
    check("tout_push_seen", empty, 0);
    n = 0;
    while (!tout && n < 200) begin @(negedge clk); n++; end
    check("tout_delay", n, 64);
    rx_done = 1'b0;
    repeat (3) @(negedge clk);
    check("tout_held", tout, 1);
    check("tout_irq", irq, 1);
    dsp_read(ADDR_CSR, 16'h4001, 1);
    dsp_read(ADDR_RX, 16'h0011, 1);
    check("tout_cleared", tout, 0);

    // Quarter-depth trigger, flush, held chip enable.
    dsp_write(ADDR_CSR, 16'h0002);
    for (int i = 0; i < 5; i++) begin
      push_char(8'(8'h21 + i), 1'b0, 1'b0);
      check("qtr_trig", trig, (i + 1 >= 4));
    end
    check("flush_pre_level", level, 5);
    dsp_write(ADDR_CSR, 16'h0001);
    check("flush_empty", empty, 1);
    check("flush_level", level, 0);
    check("flush_trig", trig, 0);
    push_char(8'h31, 1'b0, 1'b0);
    push_char(8'h32, 1'b0, 1'b0);
    check("hold_pre_level", level, 2);
    dsp_read(ADDR_RX, 16'h0031, 4);
    check("hold_level", level, 1);
    dsp_read(ADDR_RX, 16'h0032, 1);
    check("hold_empty", empty, 1);

    // Non-FIFO mode: depth 1, simultaneous push and pop while full.
    @(negedge clk); fifo_en = 1'b0;
    push_char(8'h41, 1'b0, 1'b0);
    check("nf_full", full, 1);
    @(negedge clk); rx_data = 8'h42;
    @(negedge clk); rx_done = 1'b1;
    @(negedge clk); bus.cen = 1'b0; bus.wen = 1'b1; bus.addr = ADDR_RX; exp_q.push_back(16'h0041);
    @(negedge clk); bus.cen = 1'b1;
    repeat (2) @(negedge clk);
    rx_done = 1'b0;
    repeat (3) @(negedge clk);
    check("nf_simul_ovr", ovr, 0);
    check("nf_simul_level", level, 1);
    dsp_read(ADDR_RX, 16'h0042, 1);
    push_char(8'h43, 1'b0, 1'b0);
    push_char(8'h44, 1'b0, 1'b0);
    check("nf_ovr", ovr, 1);
    check("nf_ovr_level", level, 1);
    dsp_read(ADDR_CSR, 16'hB001, 1);
    dsp_read(ADDR_RX, 16'h0043, 1);
    check("nf_empty", empty, 1);

    // Asynchronous reset in the middle of a read access.
    @(negedge clk); fifo_en = 1'b1;
    push_char(8'h61, 1'b0, 1'b0);
    push_char(8'h62, 1'b0, 1'b0);
    check("ar_pre_level", level, 2);
    @(negedge clk); bus.cen = 1'b0; bus.wen = 1'b1; bus.addr = ADDR_RX; exp_q.push_back(16'h0061);
    @(posedge clk); #3;
    rst_n = 1'b0; bus.cen = 1'b1;
    #1;
    check("ar_empty", empty, 1);
    check("ar_level", level, 0);
    check("ar_rdata", bus.rdata, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("ar_post_level", level, 0);
    push_char(8'h77, 1'b0, 1'b0);
    dsp_read(ADDR_RX, 16'h0077, 1);
    check("ar_final_empty", empty, 1);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
